// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // Divider FSM encoding
   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_CALC = 2'd1;
   localparam logic [1:0] DIV_FIX  = 2'd2;
   localparam logic [1:0] DIV_DONE = 2'd3;

   // Decoded IDU1 control; rs1_sign doubles as the signed-op flag for div/rem
   typedef struct packed {
      logic            legal;
      logic            div;
      logic            rem;
      logic            rs1_sign;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] instr_tag;
      logic [31:0]     instr;
   } idu1_out_t;

   // Two's complement negate when neg is set
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_core.sv
// One restoring shift/subtract step of the radix-2 divider.
module div_core
   import div_pkg::*;
(
   input  logic [XLEN-1:0] rem_acc,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // Shift {rem_acc, quo} left, trial-subtract the divisor, keep or restore
   always_comb begin
      shifted  = {rem_acc, quo[XLEN-1]};
      trial    = shifted - {1'b0, divisor};
      quo_next = {quo[XLEN-2:0], ~trial[XLEN]};
      rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   end

endmodule

// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One op at a time; div_busy stalls issue until the op retires.
module div
   import div_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            freeze,
   input  logic            flush,
   input  idu1_out_t       div_ctrl,
   output logic [XLEN-1:0] out,
   output logic [4:0]      out_rd_addr,
   output logic            out_rd_wr_en,
   output logic [XLEN-1:0] instr_tag_out,
   output logic [31:0]     instr_out,
   output logic            div_busy
);

   logic [1:0]      state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] rem_acc;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] divisor;
   logic            is_rem;
   logic            quo_neg;
   logic            rem_neg;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] tag_q;
   logic [31:0]     instr_q;

   logic            accept;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   // Accept decode, operand signs and the two results that bypass iteration
   always_comb begin
      accept   = (state == DIV_IDLE) && div_ctrl.legal && div_ctrl.div && !freeze && !flush;
      a_neg    = div_ctrl.rs1_sign && div_ctrl.rs1_data[XLEN-1];
      b_neg    = div_ctrl.rs1_sign && div_ctrl.rs2_data[XLEN-1];
      div_zero = (div_ctrl.rs2_data == '0);
      ovf      = div_ctrl.rs1_sign && (div_ctrl.rs1_data == MIN_NEG) && (div_ctrl.rs2_data == '1);
      if (div_zero)
         special_res = div_ctrl.rem ? div_ctrl.rs1_data : '1;
      else
         special_res = div_ctrl.rem ? '0 : MIN_NEG;
   end

   div_core u_core (
      .rem_acc  (rem_acc),
      .quo      (quo),
      .divisor  (divisor),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // FSM, iteration datapath and result registers; flush overrides freeze
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= DIV_IDLE;
         cnt           <= '0;
         rem_acc       <= '0;
         quo           <= '0;
         divisor       <= '0;
         is_rem        <= 1'b0;
         quo_neg       <= 1'b0;
         rem_neg       <= 1'b0;
         rd_q          <= '0;
         tag_q         <= '0;
         instr_q       <= '0;
         out           <= '0;
         out_rd_addr   <= '0;
         instr_tag_out <= '0;
         instr_out     <= '0;
      end else if (flush && (state != DIV_IDLE)) begin
         state <= DIV_IDLE;
      end else if (!freeze) begin
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  is_rem  <= div_ctrl.rem;
                  quo_neg <= a_neg ^ b_neg;
                  rem_neg <= a_neg;
                  rd_q    <= div_ctrl.rd_addr;
                  tag_q   <= div_ctrl.instr_tag;
                  instr_q <= div_ctrl.instr;
                  if (div_zero || ovf) begin
                     out           <= special_res;
                     out_rd_addr   <= div_ctrl.rd_addr;
                     instr_tag_out <= div_ctrl.instr_tag;
                     instr_out     <= div_ctrl.instr;
                     state         <= DIV_DONE;
                  end else begin
                     cnt     <= '0;
                     rem_acc <= '0;
                     quo     <= cond_neg(div_ctrl.rs1_data, a_neg);
                     divisor <= cond_neg(div_ctrl.rs2_data, b_neg);
                     state   <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               rem_acc <= rem_next;
               quo     <= quo_next;
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(XLEN-1))
                  state <= DIV_FIX;
            end
            DIV_FIX: begin
               out           <= is_rem ? cond_neg(rem_acc, rem_neg) : cond_neg(quo, quo_neg);
               out_rd_addr   <= rd_q;
               instr_tag_out <= tag_q;
               instr_out     <= instr_q;
               state         <= DIV_DONE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

   // Strobe is live only in DONE and is killed by a same-cycle flush
   always_comb begin
      out_rd_wr_en = (state == DIV_DONE) && !flush;
      div_busy     = (state != DIV_IDLE);
   end

   // Issue must stall on div_busy; a div presented while busy would be dropped
   a_no_div_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
      ((state != DIV_IDLE) && !flush) |-> !(div_ctrl.legal && div_ctrl.div));

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider.
module tb_div;
   import div_pkg::*;

   logic            clk;
   logic            rst_n;
   logic            freeze;
   logic            flush;
   idu1_out_t       ctrl;
   logic [XLEN-1:0] out;
   logic [4:0]      out_rd_addr;
   logic            out_rd_wr_en;
   logic [XLEN-1:0] instr_tag_out;
   logic [31:0]     instr_out;
   logic            div_busy;

   int errors = 0;
   int checks = 0;

   div dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .freeze        (freeze),
      .flush         (flush),
      .div_ctrl      (ctrl),
      .out           (out),
      .out_rd_addr   (out_rd_addr),
      .out_rd_wr_en  (out_rd_wr_en),
      .instr_tag_out (instr_tag_out),
      .instr_out     (instr_out),
      .div_busy      (div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic        rem;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_out;
      int          exp_lat;
   } vec_t;

   vec_t vecs[12];

   // RV32M semantics computed directly with language arithmetic
   function automatic logic [31:0] ref_div(input logic sgn, input logic rem,
                                            input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
         return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      end
      return rem ? (a % b) : (a / b);
   endfunction

   function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic sgn, input logic rem, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] tag, input logic [31:0] ins);
      ctrl.legal     = 1'b1;
      ctrl.div       = 1'b1;
      ctrl.rem       = rem;
      ctrl.rs1_sign  = sgn;
      ctrl.rs1_data  = a;
      ctrl.rs2_data  = b;
      ctrl.rd_addr   = rd;
      ctrl.instr_tag = tag;
      ctrl.instr     = ins;
   endtask

   task automatic clear();
      ctrl.legal = 1'b0;
      ctrl.div   = 1'b0;
   endtask

   // Issue one op, wait (bounded) for the strobe, check result, latency, busy window
   task automatic run_op(input string nm, input logic sgn, input logic rem,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input int exp_lat);
      int          lat;
      logic        busy_ok;
      logic [4:0]  rd;
      logic [31:0] tag;
      logic [31:0] ins;
      rd  = 5'($urandom);
      tag = $urandom;
      ins = $urandom;
      present(sgn, rem, a, b, rd, tag, ins);
      step();
      clear();
      lat     = 1;
      busy_ok = 1'b1;
      while (!out_rd_wr_en && lat < 100) begin
         if (!div_busy) busy_ok = 1'b0;
         step();
         lat++;
      end
      if (!div_busy) busy_ok = 1'b0;
      chk({nm, "_lat"},  32'(lat), 32'(exp_lat));
      chk({nm, "_out"},  out, exp_out);
      chk({nm, "_rd"},   32'(out_rd_addr), 32'(rd));
      chk({nm, "_tag"},  instr_tag_out, tag);
      chk({nm, "_ins"},  instr_out, ins);
      chk({nm, "_busy"}, 32'(busy_ok), 32'd1);
      step();
      chk({nm, "_strobe_off"}, 32'(out_rd_wr_en), 32'd0);
      chk({nm, "_idle"},       32'(div_busy), 32'd0);
   endtask

   initial begin
      int lat;
      logic [31:0] a, b;
      logic sgn, rem;

      vecs[0]  = '{1'b1, 1'b0, 32'h0000_0014, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_0014, 32'hFFFF_FFFD, 32'h0000_0002, 34};
      vecs[2]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 34};
      vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 34};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1};
      vecs[6]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[8]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
      vecs[10] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
      vecs[11] = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};

      rst_n  = 1'b0;
      freeze = 1'b0;
      flush  = 1'b0;
      ctrl   = '0;
      repeat (3) step();
      chk("rst_out",    out, 32'd0);
      chk("rst_strobe", 32'(out_rd_wr_en), 32'd0);
      chk("rst_busy",   32'(div_busy), 32'd0);
      chk("rst_rd",     32'(out_rd_addr), 32'd0);
      chk("rst_tag",    instr_tag_out, 32'd0);
      chk("rst_ins",    instr_out, 32'd0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i])
         run_op($sformatf("v%0d", i), vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b,
                vecs[i].exp_out, vecs[i].exp_lat);

      // Freeze held across DONE: strobe and data stay up, then one retiring cycle
      present(1'b1, 1'b0, 32'd100, 32'd7, 5'd3, 32'h11, 32'h22);
      step();
      clear();
      lat = 1;
      while (!out_rd_wr_en && lat < 100) begin step(); lat++; end
      chk("fzd_lat", 32'(lat), 32'd34);
      freeze = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("fzd_strobe%0d", i), 32'(out_rd_wr_en), 32'd1);
         chk($sformatf("fzd_out%0d", i), out, 32'd14);
         step();
      end
      freeze = 1'b0;
      #1;
      chk("fzd_retire", 32'(out_rd_wr_en), 32'd1);
      step();
      chk("fzd_after", 32'(out_rd_wr_en), 32'd0);
      chk("fzd_idle",  32'(div_busy), 32'd0);

      // Freeze for three cycles mid-CALC stretches latency by three
      present(1'b1, 1'b0, 32'd100, 32'd7, 5'd4, 32'h33, 32'h44);
      step();
      clear();
      lat = 1;
      repeat (8) begin step(); lat++; end
      freeze = 1'b1;
      repeat (3) begin step(); lat++; end
      freeze = 1'b0;
      #1;
      while (!out_rd_wr_en && lat < 100) begin step(); lat++; end
      chk("fzc_lat", 32'(lat), 32'd37);
      chk("fzc_out", out, 32'd14);
      step();

      // Flush in CALC kills the op; the next op is accepted straight away
      present(1'b1, 1'b0, 32'd100, 32'd7, 5'd5, 32'h55, 32'h66);
      step();
      clear();
      repeat (9) step();
      flush = 1'b1;
      #1;
      chk("fl_strobe", 32'(out_rd_wr_en), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_busy", 32'(div_busy), 32'd0);
      chk("fl_nowb", 32'(out_rd_wr_en), 32'd0);
      run_op("fl_next", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 34);

      // Flush in DONE suppresses the strobe of a special-case op
      present(1'b1, 1'b0, 32'd7, 32'd0, 5'd6, 32'h77, 32'h88);
      step();
      clear();
      chk("fld_pre", 32'(out_rd_wr_en), 32'd1);
      flush = 1'b1;
      #1;
      chk("fld_strobe", 32'(out_rd_wr_en), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fld_busy", 32'(div_busy), 32'd0);

      // Flush in IDLE blocks accept
      flush = 1'b1;
      present(1'b0, 1'b0, 32'd9, 32'd3, 5'd7, 32'h99, 32'hAA);
      step();
      clear();
      flush = 1'b0;
      #1;
      chk("fli_busy", 32'(div_busy), 32'd0);

      // Randomised ops against the arithmetic reference
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom);
         rem = 1'($urandom);
         a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = $urandom;
            default: b = 32'hFFFF_FFFF;
         endcase
         run_op($sformatf("r%0d", i), sgn, rem, a, b, ref_div(sgn, rem, a, b), ref_lat(sgn, a, b));
      end

      // Mid-op reset returns everything to reset values with no writeback
      present(1'b1, 1'b1, 32'd100, 32'd7, 5'd9, 32'hBB, 32'hCC);
      step();
      clear();
      repeat (5) step();
      rst_n = 1'b0;
      step();
      chk("mrst_busy",   32'(div_busy), 32'd0);
      chk("mrst_strobe", 32'(out_rd_wr_en), 32'd0);
      chk("mrst_out",    out, 32'd0);
      chk("mrst_tag",    instr_tag_out, 32'd0);
      rst_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
